uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//   MMIO initiator that drives the UART peripheral's register interface to load a program image
//   into instruction memory. On start it programs the baud divisor, receives a 4-byte
//   little-endian word count, then N little-endian 32-bit words, and writes each to IMEM.
//   It finishes by transmitting ACK (0x06) or NAK (0x15). Sits beside the core on the SoC data bus.
// PARAMETERS
//   BASE_ADDR     32'h0000_2000  UART register base (baud +0x0, getchar +0x4, setchar +0x8, status +0xC)
//   BAUD_DIV      32'd434        value written to baud register (50 MHz / 115200)
//   IMEM_AW       14             IMEM word-address width; max image = 2**IMEM_AW words
//   TIMEOUT_CYC   32'd5_000_000  max idle cycles between bytes once the header has started
// PORTS
//   clk           in   1        system clock
//   rst           in   1        asynchronous, active-high reset
//   start         in   1        1-cycle pulse: begin load (ignored while busy)
//   busy          out  1        high from accepted start until DONE/ERROR
//   done          out  1        sticky: load ended with ACK sent; cleared by next start
//   error         out  1        sticky: load ended with NAK sent; cleared by next start
//   words_loaded  out  IMEM_AW+1  count of words written to IMEM this load
//   mmio_address  out  32       UART register address
//   mmio_store    out  32       write data
//   mmio_read     out  1        1 = read, 0 = write
//   mmio_enable   out  1        access strobe; each cycle high = one access
//   mmio_fetch    in   32       read data, combinational from mmio_address (same-cycle valid)
//   imem_we       out  1        1-cycle IMEM write strobe
//   imem_addr     out  IMEM_AW  IMEM word address
//   imem_wdata    out  32       IMEM write word
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-load aborts at once; no further
//     IMEM/MMIO writes occur.
//   Status bits: [0] tx_done, [1] rx_rdy. Status reads have no side effect; a getchar read clears rx_rdy.
//   Unused cycles: mmio_enable=0, mmio_read=1, mmio_address holds its last value.
//   FSM:
//   IDLE      start -> clear done/error/words_loaded/byte_idx; go SET_BAUD.
//   SET_BAUD  1 cycle write: addr=BASE+0x0, store=BAUD_DIV, read=0, en=1 -> POLL_RX.
//   POLL_RX   read BASE+0xC every cycle. fetch[1]=1 -> READ_CHAR.
//             Timeout counter runs only after header byte 0 has been received; it resets on
//             every byte. Reaching TIMEOUT_CYC -> nak -> SEND.
//   READ_CHAR exactly 1 cycle read of BASE+0x4; capture fetch[7:0] into shift reg
//             (byte k goes to bits 8k+7:8k). byte_idx++.
//             If byte_idx wraps 3->0: header phase -> HDR_CHK, else -> WRITE_MEM. Otherwise -> POLL_RX.
//   HDR_CHK   count==0 -> ack -> SEND. count>2**IMEM_AW -> nak -> SEND. Else -> POLL_RX (data phase).
//   WRITE_MEM imem_we=1 for 1 cycle; imem_addr=words_loaded[IMEM_AW-1:0]; wdata=assembled word.
//             words_loaded++. If words_loaded==count -> ack -> SEND, else -> POLL_RX.
//   SEND      1 cycle write BASE+0x8, store={24'h0,0x06|0x15} -> TX_WAIT.
//   TX_WAIT   1 dead cycle (en=0), then poll BASE+0xC until fetch[0]=1 -> DONE/ERROR.
//   DONE/ERROR set done (ack) or error (nak); busy=0 -> IDLE.
//   Latency: a byte costs >=2 MMIO cycles after rx_rdy rises; IMEM write 1 cycle after 4th byte.
//   Arithmetic: count is 32-bit unsigned. words_loaded never exceeds count.
//     Image of exactly 2**IMEM_AW words is legal and fills addr 0..2**IMEM_AW-1.
//   Exactly one mmio_enable cycle per READ_CHAR, so rx_rdy clears exactly once per byte.
// TESTING
//   1 Reset, start; UART model: cnt=2, bytes 78 56 34 12 EF BE AD DE ->
//     baud write 434; IMEM[0]=0x12345678, IMEM[1]=0xDEADBEEF; setchar 0x06; done=1; words_loaded=2.
//   2 Header count=0 -> no imem_we; ACK 0x06 sent; done=1.
//   3 IMEM_AW=4, count=17 -> NAK 0x15, error=1, no imem_we.
//     Repeat with count=16 -> 16 writes, addr 0..15, done=1.
//   4 Stall after byte 5 for TIMEOUT_CYC (reduced to 100) -> NAK, error=1, words_loaded=1.
//   5 Assert rst during 3rd data word -> all outputs 0 next edge; no later imem_we.
//     New start runs a full load cleanly.
//   6 start pulses while busy -> ignored; exactly one getchar read per rx_rdy rise
//     (check clr count == bytes sent).

Source files
------------

// File: rtl/uart_boot_loader.sv
// Boot loader: drives the UART MMIO registers to pull a length-prefixed image into IMEM.
// Latency: >=2 MMIO cycles per byte after rx_rdy; IMEM write one cycle after the 4th byte of a word.
// Backpressure: polls UART status every idle cycle; stalls indefinitely until header byte 0, then times out.
//
// Ports: clk/rst (async active-high); start/busy/done/error control; words_loaded progress;
//        mmio_* initiator bus to the UART (mmio_fetch is same-cycle read data); imem_* write port.
module uart_boot_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter logic [31:0] BAUD_DIV    = 32'd434,
    parameter int          IMEM_AW     = 14,
    parameter logic [31:0] TIMEOUT_CYC = 32'd5_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [IMEM_AW:0]   words_loaded,
    output logic [31:0]        mmio_address,
    output logic [31:0]        mmio_store,
    output logic               mmio_read,
    output logic               mmio_enable,
    input  logic [31:0]        mmio_fetch,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_SET_BAUD, S_POLL_RX, S_READ_CHAR, S_HDR_CHK,
        S_WRITE_MEM, S_SEND, S_TX_WAIT, S_TX_POLL, S_FIN
    } state_t;

    localparam logic [32:0] MAX_WORDS = 33'd1 << IMEM_AW;
    localparam logic [31:0] ADDR_BAUD = BASE_ADDR;
    localparam logic [31:0] ADDR_GETC = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_SETC = BASE_ADDR + 32'h8;
    localparam logic [31:0] ADDR_STAT = BASE_ADDR + 32'hC;

    state_t             state, state_nx;
    logic [31:0]        shreg;
    logic [IMEM_AW:0]   count_q;
    logic [31:0]        tmo;
    logic [1:0]         byte_idx;
    logic               hdr_phase;
    logic               started;
    logic               nak;
    logic               live;       // 0 only while/just after reset so every output reads 0 in reset
    logic [31:0]        addr_q;
    logic [31:0]        addr_cur;
    logic [IMEM_AW:0]   wl_inc;
    logic               unused_fetch;

    assign unused_fetch = ^mmio_fetch[31:8];
    assign wl_inc       = words_loaded + {{IMEM_AW{1'b0}}, 1'b1};
    assign busy         = (state != S_IDLE) && (state != S_FIN);
    assign imem_addr    = words_loaded[IMEM_AW-1:0];
    assign imem_wdata   = shreg;
    // Address holds its last accessed value on idle cycles.
    assign mmio_address = mmio_enable ? addr_cur : addr_q;

    always_comb begin
        state_nx    = state;
        mmio_enable = 1'b0;
        mmio_read   = live;
        mmio_store  = 32'h0;
        addr_cur    = addr_q;
        imem_we     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_SET_BAUD;
            S_SET_BAUD: begin
                mmio_enable = 1'b1;
                mmio_read   = 1'b0;
                addr_cur    = ADDR_BAUD;
                mmio_store  = BAUD_DIV;
                state_nx    = S_POLL_RX;
            end
            S_POLL_RX: begin
                mmio_enable = 1'b1;
                mmio_read   = 1'b1;
                addr_cur    = ADDR_STAT;
                if (mmio_fetch[1])
                    state_nx = S_READ_CHAR;
                else if (started && (tmo >= TIMEOUT_CYC - 32'd1))
                    state_nx = S_SEND;
            end
            S_READ_CHAR: begin
                mmio_enable = 1'b1;
                mmio_read   = 1'b1;
                addr_cur    = ADDR_GETC;
                if (byte_idx == 2'd3)
                    state_nx = hdr_phase ? S_HDR_CHK : S_WRITE_MEM;
                else
                    state_nx = S_POLL_RX;
            end
            S_HDR_CHK: begin
                if (shreg == 32'h0 || {1'b0, shreg} > MAX_WORDS)
                    state_nx = S_SEND;
                else
                    state_nx = S_POLL_RX;
            end
            S_WRITE_MEM: begin
                imem_we  = 1'b1;
                state_nx = (wl_inc == count_q) ? S_SEND : S_POLL_RX;
            end
            S_SEND: begin
                mmio_enable = 1'b1;
                mmio_read   = 1'b0;
                addr_cur    = ADDR_SETC;
                mmio_store  = nak ? 32'h15 : 32'h06;
                state_nx    = S_TX_WAIT;
            end
            // Dead cycle lets the UART drop tx_done before the first status poll.
            S_TX_WAIT: state_nx = S_TX_POLL;
            S_TX_POLL: begin
                mmio_enable = 1'b1;
                mmio_read   = 1'b1;
                addr_cur    = ADDR_STAT;
                if (mmio_fetch[0]) state_nx = S_FIN;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            live         <= 1'b0;
            addr_q       <= 32'h0;
            shreg        <= 32'h0;
            count_q      <= '0;
            tmo          <= 32'h0;
            byte_idx     <= 2'd0;
            hdr_phase    <= 1'b0;
            started      <= 1'b0;
            nak          <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (mmio_enable) addr_q <= mmio_address;
            case (state)
                S_IDLE: if (start) begin
                    done         <= 1'b0;
                    error        <= 1'b0;
                    words_loaded <= '0;
                    byte_idx     <= 2'd0;
                    hdr_phase    <= 1'b1;
                    started      <= 1'b0;
                    nak          <= 1'b0;
                    tmo          <= 32'h0;
                    shreg        <= 32'h0;
                end
                S_POLL_RX: begin
                    if (!mmio_fetch[1] && started) tmo <= tmo + 32'd1;
                    if (state_nx == S_SEND) nak <= 1'b1;
                end
                S_READ_CHAR: begin
                    shreg[{byte_idx, 3'b000} +: 8] <= mmio_fetch[7:0];
                    byte_idx <= byte_idx + 2'd1;
                    started  <= 1'b1;
                    tmo      <= 32'h0;
                end
                S_HDR_CHK: begin
                    count_q   <= shreg[IMEM_AW:0];
                    hdr_phase <= 1'b0;
                    if ({1'b0, shreg} > MAX_WORDS) nak <= 1'b1;
                end
                S_WRITE_MEM: words_loaded <= wl_inc;
                S_TX_POLL: if (mmio_fetch[0]) begin
                    done  <= ~nak;
                    error <= nak;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;
    localparam int          AW   = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic [AW:0]   words_loaded;
    logic [31:0]   mmio_address, mmio_store, mmio_fetch;
    logic          mmio_read, mmio_enable;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    uart_boot_loader #(.BASE_ADDR(BASE), .BAUD_DIV(32'd434), .IMEM_AW(AW), .TIMEOUT_CYC(32'd100)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded), .mmio_address(mmio_address), .mmio_store(mmio_store),
        .mmio_read(mmio_read), .mmio_enable(mmio_enable), .mmio_fetch(mmio_fetch),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // UART peripheral model + IMEM/bus observers
    logic [7:0]  feed_mem [0:255];
    int          feed_len = 0;
    int          ptr, gap, tx_tmr, we_cnt, clr_cnt, tx_cnt, order_err;
    logic        rx_rdy, tx_done;
    logic [7:0]  rx_byte, last_tx;
    logic [31:0] baud_val;
    logic [31:0] imem_got [0:15];

    assign mmio_fetch = (mmio_address == BASE + 32'h4) ? {24'h0, rx_byte} :
                        (mmio_address == BASE + 32'hC) ? {30'h0, rx_rdy, tx_done} : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            ptr <= 0; gap <= 3; tx_tmr <= 0; we_cnt <= 0; clr_cnt <= 0; tx_cnt <= 0;
            order_err <= 0; rx_rdy <= 1'b0; tx_done <= 1'b1; rx_byte <= 8'h0;
            last_tx <= 8'h0; baud_val <= 32'h0;
        end else begin
            if (mmio_enable && mmio_read && mmio_address == BASE + 32'h4) begin
                clr_cnt <= clr_cnt + 1;
                rx_rdy  <= 1'b0;
            end
            if (mmio_enable && !mmio_read && mmio_address == BASE + 32'h8) begin
                tx_cnt  <= tx_cnt + 1;
                last_tx <= mmio_store[7:0];
                tx_done <= 1'b0;
                tx_tmr  <= 5;
            end else if (tx_tmr > 0) begin
                tx_tmr <= tx_tmr - 1;
                if (tx_tmr == 1) tx_done <= 1'b1;
            end
            if (mmio_enable && !mmio_read && mmio_address == BASE) baud_val <= mmio_store;
            if (!rx_rdy && ptr < feed_len) begin
                if (gap == 0) begin
                    rx_byte <= feed_mem[ptr];
                    ptr     <= ptr + 1;
                    rx_rdy  <= 1'b1;
                    gap     <= $urandom_range(0, 6);
                end else begin
                    gap <= gap - 1;
                end
            end
            if (imem_we) begin
                we_cnt <= we_cnt + 1;
                imem_got[imem_addr] <= imem_wdata;
                if (32'(imem_addr) != 32'(we_cnt)) order_err <= order_err + 1;
            end
        end
    end

    logic [31:0] words [0:15];

    task automatic build_feed(input logic [31:0] cnt, input int nbytes, input bit fixed);
        for (int w = 0; w < 16; w++) words[w] = $urandom;
        if (fixed) begin
            words[0] = 32'h1234_5678;
            words[1] = 32'hDEAD_BEEF;
        end
        for (int i = 0; i < 4; i++) feed_mem[i] = cnt[8*i +: 8];
        for (int w = 0; w < 16; w++)
            for (int b = 0; b < 4; b++) feed_mem[4 + 4*w + b] = words[w][8*b +: 8];
        feed_len = nbytes;
    endtask

    task automatic kick();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for busy to drop while throwing stray start pulses at the busy loader.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if ($urandom_range(0, 7) == 0) start = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic run_case(input string name, input logic [31:0] cnt, input int nbytes, input bit fixed);
        bit ok;
        bit exp_ack;
        int exp_wl;
        build_feed(cnt, nbytes, fixed);
        kick();
        wait_idle(ok);
        chk({name, ":finished"}, 32'(ok), 32'd1);
        if (!ok) return;
        // Reference outcome from the image-length rules
        if (cnt == 0) begin
            exp_ack = 1'b1; exp_wl = 0;
        end else if (cnt > 32'd16) begin
            exp_ack = 1'b0; exp_wl = 0;
        end else if ((nbytes - 4) / 4 >= int'(cnt)) begin
            exp_ack = 1'b1; exp_wl = int'(cnt);
        end else begin
            exp_ack = 1'b0; exp_wl = (nbytes - 4) / 4;
        end
        chk({name, ":done"},     32'(done),         32'(exp_ack));
        chk({name, ":error"},    32'(error),        32'(!exp_ack));
        chk({name, ":wl"},       32'(words_loaded), 32'(exp_wl));
        chk({name, ":we_cnt"},   32'(we_cnt),       32'(exp_wl));
        chk({name, ":tx_cnt"},   32'(tx_cnt),       32'd1);
        chk({name, ":tx_byte"},  32'(last_tx),      exp_ack ? 32'h06 : 32'h15);
        chk({name, ":baud"},     baud_val,          32'd434);
        chk({name, ":getchar"},  32'(clr_cnt),      32'(nbytes));
        chk({name, ":addr_seq"}, 32'(order_err),    32'd0);
        for (int i = 0; i < exp_wl; i++) chk({name, ":imem"}, imem_got[i], words[i]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        repeat (2) @(negedge clk);
        chk("rst:busy",  32'(busy),         32'd0);
        chk("rst:done",  32'(done),         32'd0);
        chk("rst:error", 32'(error),        32'd0);
        chk("rst:wl",    32'(words_loaded), 32'd0);
        chk("rst:en",    32'(mmio_enable),  32'd0);
        chk("rst:we",    32'(imem_we),      32'd0);
        chk("rst:addr",  mmio_address,      32'd0);

        run_case("basic",   32'd2,  12, 1'b1);
        run_case("zero",    32'd0,  4,  1'b0);
        run_case("over",    32'd17, 4,  1'b0);
        run_case("full",    32'd16, 68, 1'b0);
        run_case("timeout", 32'd3,  10, 1'b0);
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 16);
            run_case("rand", 32'(n), 4 + 4*n, 1'b0);
        end

        // Reset in the middle of the third data word
        build_feed(32'd5, 24, 1'b0);
        kick();
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (we_cnt == 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midrst:reached", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst:busy", 32'(busy),         32'd0);
        chk("midrst:en",   32'(mmio_enable),  32'd0);
        chk("midrst:we",   32'(imem_we),      32'd0);
        chk("midrst:wl",   32'(words_loaded), 32'd0);
        chk("midrst:addr", mmio_address,      32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("midrst:no_we", 32'(we_cnt), 32'd0);
        chk("midrst:no_tx", 32'(tx_cnt), 32'd0);
        run_case("after_rst", 32'd5, 24, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
